linebuffer_scanout: RTL and testbench
=====================================

// Module: linebuffer_scanout
// PURPOSE
//  Ping-pong line buffer between the sprite drawers and the VGA pixel path. The draw side writes
//  pixel_col/pixel_data/wren from the sprite drawers into the draw bank. The scan side reads the
//  display bank one pixel per request and clears each pixel to background after it is read.
//  An external per-line swap pulse exchanges the two banks.
// PARAMETERS
//  LINE_WIDTH  640       visible columns per line; valid cols 0..LINE_WIDTH-1
//  COL_W       10        column address width
//  PIX_W       16        pixel width; bit 15 = transparent flag, [14:0] = RGB555
//  BG_COLOR    16'h0000  value written by init sweep and clear-on-read
// PORTS
//  clk         in   1      system clock
//  reset       in   1      synchronous, active-high
//  swap        in   1      1-clk pulse at end of active line; exchanges draw/display banks
//  wr_col      in   COL_W  draw-side column (from sprite drawer pixel_col)
//  wr_data     in   PIX_W  draw-side pixel (from sprite drawer pixel_data)
//  wr_en       in   1      draw-side write strobe (from sprite drawer wren)
//  rd_en       in   1      scan-side read request
//  rd_col      in   COL_W  scan-side column
//  rd_data     out  PIX_W  pixel read from display bank
//  rd_valid    out  1      rd_data qualifier
//  bank_sel    out  1      current draw bank index; display bank = ~bank_sel
//  init_busy   out  1      init sweep in progress; all accesses ignored
// BEHAVIOUR
//  - Reset values: bank_sel=0, rd_valid=0, rd_data=BG_COLOR, init_busy=1, FSM=INIT, sweep counter=0.
//  - FSM INIT: each cycle writes BG_COLOR at sweep counter into BOTH banks.
//    Counter runs 0..LINE_WIDTH-1. On the cycle after the write of LINE_WIDTH-1, go to RUN and drop init_busy.
//    INIT lasts exactly LINE_WIDTH cycles after reset deasserts.
//    In INIT: wr_en, rd_en and swap are ignored; rd_valid stays 0.
//  - FSM RUN: no exit except reset. Reset mid-operation aborts any in-flight read (rd_valid=0 next edge).
//    It also returns bank_sel to 0 and re-runs INIT.
//  - Draw write: wr_en && wr_col<LINE_WIDTH writes wr_data to bank[bank_sel] at the same edge.
//    wr_col>=LINE_WIDTH is dropped silently; no aliasing or modulo.
//    The transparent bit is stored as given; filtering is upstream.
//  - Read latency 2: rd_en at cycle N captures {~bank_sel, rd_col}; the RAM read is at edge N+1.
//    rd_data and rd_valid are registered and valid during cycle N+2.
//    rd_valid pulses once per accepted rd_en; back-to-back rd_en gives one result per cycle.
//  - Clear-on-read: at edge N+1 write BG_COLOR to the captured bank and column. The read-before-write RAM
//    returns old data. Back-to-back reads of the same col return old data, then BG_COLOR.
//  - rd_col>=LINE_WIDTH: rd_valid still pulses at N+2 with rd_data=BG_COLOR; no RAM access, no clear.
//  - swap: bank_sel toggles at the swap edge.
//    A wr_en in the same cycle as swap writes the OLD draw bank, which becomes the display bank.
//    A read captured before or at the swap edge completes on its captured bank, including its clear.
//  - Draw and clear never target the same bank in one cycle. Each bank has one write port: the draw port
//    on bank[bank_sel] and the clear/init port on the other. A clear still pending in the old display bank
//    after a swap wins that bank's port for one cycle, and a coincident draw write to that bank is dropped.
//    Upstream never draws in the cycle right after a swap.
//  - Unread display columns are not cleared. Scanout reads every visible column each line.
// STRUCTURE
//  - video_pkg: LINE_WIDTH, COL_W, PIX_W, BG_COLOR, TRANSP_BIT=15, typedef pixel_t, typedef col_t.
//    sprite_drawer and vga path share these.
//  - Sub-module linebuffer_bank (simple dual-port RAM, 1 write + 1 registered read, read-before-write,
//    LINE_WIDTH x PIX_W), instantiated twice.
//  - Top level holds the INIT/RUN FSM, sweep counter, bank_sel, 2-stage read pipeline and per-bank
//    write-port muxes.
// TESTING
//  1 Release reset -> init_busy high exactly 640 cycles. Then read cols 0..639 of both banks (swap between)
//    -> all 16'h0000.
//  2 wr col 5 data 16'h1234, swap, rd_en col 5 -> rd_data 16'h1234 rd_valid at +2.
//    Re-read col 5 next line -> 16'h0000 (cleared).
//  3 wr col 700 data 16'hBEEF; swap; read col 700 -> BG_COLOR with rd_valid. Read col 60 -> 16'h0000
//    (no alias write).
//  4 wr col 3 16'h00AA, swap, rd_en col 3 at N with swap at N -> rd_data 16'h00AA at N+2.
//    The old bank's col 3 reads 16'h0000 after a second swap.
//  5 wr_en col 9 16'h7C00 in same cycle as swap -> next read of col 9 returns 16'h7C00.
//  6 Reset asserted mid-scanout with rd_en streaming -> rd_valid 0 next edge, bank_sel 0, init_busy 1.
//    After 640 cycles all reads return 16'h0000.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video-line types and constants for the sprite drawers, line buffer and VGA path.
package video_pkg;
    localparam int LINE_WIDTH = 640;
    localparam int COL_W      = 10;
    localparam int PIX_W      = 16;
    localparam int TRANSP_BIT = 15;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [COL_W-1:0] col_t;

    localparam pixel_t BG_COLOR = 16'h0000;
    localparam col_t   LAST_COL = 10'(LINE_WIDTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } lb_state_e;

    // Columns past the visible line are dropped, never wrapped.
    function automatic logic col_visible(input col_t col);
        return (col <= LAST_COL);
    endfunction
endpackage

// File: rtl/linebuffer_scanout_if.sv
// Draw-side write and scan-side read signals of the ping-pong line buffer.
interface linebuffer_scanout_if;
    import video_pkg::*;

    logic   wr_en;
    col_t   wr_col;
    pixel_t wr_data;
    logic   rd_en;
    col_t   rd_col;
    pixel_t rd_data;
    logic   rd_valid;

    modport master (
        output wr_en, wr_col, wr_data, rd_en, rd_col,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_col, wr_data, rd_en, rd_col,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/linebuffer_bank.sv
// One line of pixel storage: single write port, registered read port, read-before-write.
module linebuffer_bank
    import video_pkg::*;
(
    input  logic   clk,
    input  logic   we,
    input  col_t   waddr,
    input  pixel_t wdata,
    input  logic   re,
    input  col_t   raddr,
    output pixel_t rdata
);
    pixel_t mem [LINE_WIDTH];
    pixel_t rdata_q;

    // The read samples the array before a same-edge write lands, so clear-on-read returns old data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/linebuffer_scanout.sv
// Ping-pong line buffer: the sprite drawers fill bank[bank_sel] while scanout reads and clears the other.
module linebuffer_scanout
    import video_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 swap,
    linebuffer_scanout_if.slave  lb,
    output logic                 bank_sel,
    output logic                 init_busy
);
    lb_state_e state_q, state_d;
    col_t      sweep_q, sweep_d;
    logic      bank_sel_q, bank_sel_d;
    logic      init_busy_q, init_busy_d;
    // Stage 1 holds the captured read request; stage 2 qualifies the bank read data.
    logic      s1_valid_q, s1_valid_d;
    logic      s1_bank_q, s1_bank_d;
    logic      s1_oor_q, s1_oor_d;
    col_t      s1_col_q, s1_col_d;
    logic      rd_valid_q, rd_valid_d;
    logic      rd_bg_q, rd_bg_d;
    logic      rd_bank_q, rd_bank_d;

    logic      [1:0] bank_we;
    logic      [1:0] bank_re;
    col_t      bank_waddr [2];
    pixel_t    bank_wdata [2];
    pixel_t    bank_rdata [2];

    // Next-state for the INIT/RUN FSM, sweep counter, bank select and read pipeline.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        bank_sel_d  = bank_sel_q;
        s1_valid_d  = 1'b0;
        s1_bank_d   = s1_bank_q;
        s1_oor_d    = s1_oor_q;
        s1_col_d    = s1_col_q;
        rd_valid_d  = s1_valid_q;
        rd_bg_d     = s1_valid_q ? s1_oor_q  : rd_bg_q;
        rd_bank_d   = s1_valid_q ? s1_bank_q : rd_bank_q;
        case (state_q)
            ST_INIT: begin
                if (sweep_q == LAST_COL) begin
                    state_d = ST_RUN;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 10'd1;
                end
            end
            ST_RUN: begin
                if (swap) begin
                    bank_sel_d = ~bank_sel_q;
                end else begin
                    bank_sel_d = bank_sel_q;
                end
                if (lb.rd_en) begin
                    s1_valid_d = 1'b1;
                    s1_bank_d  = ~bank_sel_q;
                    s1_col_d   = lb.rd_col;
                    s1_oor_d   = ~col_visible(lb.rd_col);
                end else begin
                    s1_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
                sweep_d = '0;
            end
        endcase
        init_busy_d = (state_d == ST_INIT);
    end

    // Per-bank write-port mux: init sweep, then a pending clear, then a draw write to the draw bank.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_we[b]    = 1'b0;
            bank_re[b]    = 1'b0;
            bank_waddr[b] = sweep_q;
            bank_wdata[b] = BG_COLOR;
            if (state_q == ST_INIT) begin
                bank_we[b] = 1'b1;
            end else if (s1_valid_q && !s1_oor_q && (s1_bank_q == b[0])) begin
                bank_we[b]    = 1'b1;
                bank_re[b]    = 1'b1;
                bank_waddr[b] = s1_col_q;
            end else if (lb.wr_en && col_visible(lb.wr_col) && (bank_sel_q == b[0])) begin
                bank_we[b]    = 1'b1;
                bank_waddr[b] = lb.wr_col;
                bank_wdata[b] = lb.wr_data;
            end else begin
                bank_we[b] = 1'b0;
            end
        end
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            bank_sel_q  <= 1'b0;
            init_busy_q <= 1'b1;
            s1_valid_q  <= 1'b0;
            s1_bank_q   <= 1'b0;
            s1_oor_q    <= 1'b0;
            s1_col_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_bg_q     <= 1'b1;
            rd_bank_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            bank_sel_q  <= bank_sel_d;
            init_busy_q <= init_busy_d;
            s1_valid_q  <= s1_valid_d;
            s1_bank_q   <= s1_bank_d;
            s1_oor_q    <= s1_oor_d;
            s1_col_q    <= s1_col_d;
            rd_valid_q  <= rd_valid_d;
            rd_bg_q     <= rd_bg_d;
            rd_bank_q   <= rd_bank_d;
        end
    end

    linebuffer_bank u_bank0 (
        .clk   (clk),
        .we    (bank_we[0]),
        .waddr (bank_waddr[0]),
        .wdata (bank_wdata[0]),
        .re    (bank_re[0]),
        .raddr (s1_col_q),
        .rdata (bank_rdata[0])
    );

    linebuffer_bank u_bank1 (
        .clk   (clk),
        .we    (bank_we[1]),
        .waddr (bank_waddr[1]),
        .wdata (bank_wdata[1]),
        .re    (bank_re[1]),
        .raddr (s1_col_q),
        .rdata (bank_rdata[1])
    );

    // Bank read registers are the data stage; rd_bg_q forces background after reset or off-line reads.
    assign lb.rd_data  = rd_bg_q ? BG_COLOR : bank_rdata[rd_bank_q];
    assign lb.rd_valid = rd_valid_q;
    assign bank_sel    = bank_sel_q;
    assign init_busy   = init_busy_q;
endmodule

// File: tb/tb_linebuffer_scanout.sv
// Directed bench for linebuffer_scanout: init sweep, draw/scan, clear-on-read, swap corners, reset.
module tb_linebuffer_scanout;
    import video_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic swap;
    logic bank_sel;
    logic init_busy;
    int   total = 0;
    int   bad   = 0;
    logic exp_bank = 1'b0;

    linebuffer_scanout_if lb ();

    linebuffer_scanout dut (
        .clk       (clk),
        .reset     (reset),
        .swap      (swap),
        .lb        (lb),
        .bank_sel  (bank_sel),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at the negedge where reset was just released.
    task automatic wait_init(input string tag);
        int cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!init_busy) break;
            cnt++;
            @(negedge clk);
        end
        chk(tag, 32'(cnt), 32'd640);
    endtask

    task automatic do_swap();
        @(negedge clk);
        swap = 1'b1;
        @(negedge clk);
        swap = 1'b0;
        exp_bank = ~exp_bank;
        chk("bank_sel", {31'd0, bank_sel}, {31'd0, exp_bank});
        @(negedge clk);
    endtask

    task automatic do_write(input col_t col, input pixel_t data);
        @(negedge clk);
        lb.wr_en   = 1'b1;
        lb.wr_col  = col;
        lb.wr_data = data;
        @(negedge clk);
        lb.wr_en   = 1'b0;
    endtask

    task automatic do_read(input string tag, input col_t col, input pixel_t exp);
        @(negedge clk);
        lb.rd_en  = 1'b1;
        lb.rd_col = col;
        @(negedge clk);
        lb.rd_en  = 1'b0;
        chk({tag, "_lat1"}, {31'd0, lb.rd_valid}, 32'd0);
        @(negedge clk);
        chk(tag, {15'd0, lb.rd_valid, lb.rd_data}, {15'd0, 1'b1, exp});
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, lb.rd_valid}, 32'd0);
    endtask

    // Streams one read per cycle over the whole line; results trail the requests by two cycles.
    task automatic stream_zero(input string tag);
        for (int i = 0; i < LINE_WIDTH + 2; i++) begin
            @(negedge clk);
            if (i >= 2) chk(tag, {15'd0, lb.rd_valid, lb.rd_data}, {15'd0, 1'b1, BG_COLOR});
            lb.rd_en  = (i < LINE_WIDTH);
            lb.rd_col = (i < LINE_WIDTH) ? 10'(i) : 10'd0;
        end
    endtask

    initial begin
        reset = 1'b1;
        swap = 1'b0;
        lb.wr_en = 1'b0;
        lb.wr_col = '0;
        lb.wr_data = '0;
        lb.rd_en = 1'b0;
        lb.rd_col = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bank_sel", {31'd0, bank_sel}, 32'd0);
        chk("rst_rd_valid", {31'd0, lb.rd_valid}, 32'd0);
        chk("rst_rd_data", {16'd0, lb.rd_data}, {16'd0, BG_COLOR});
        chk("rst_init_busy", {31'd0, init_busy}, 32'd1);

        // 1: init length, both banks background
        reset = 1'b0;
        wait_init("init_len");
        stream_zero("init_bank1");
        do_swap();
        stream_zero("init_bank0");

        // 2: draw, swap, read, clear-on-read, back-to-back same column
        do_write(10'd5, 16'h1234);
        do_write(10'd20, 16'h0ABC);
        do_swap();
        do_read("rd_col5", 10'd5, 16'h1234);
        do_read("rd_col5_clr", 10'd5, 16'h0000);
        @(negedge clk);
        lb.rd_en  = 1'b1;
        lb.rd_col = 10'd20;
        @(negedge clk);
        @(negedge clk);
        lb.rd_en  = 1'b0;
        chk("b2b_first", {15'd0, lb.rd_valid, lb.rd_data}, {15'd0, 1'b1, 16'h0ABC});
        @(negedge clk);
        chk("b2b_second", {15'd0, lb.rd_valid, lb.rd_data}, {15'd0, 1'b1, 16'h0000});

        // 3: off-line column dropped, no alias
        do_write(10'd700, 16'hBEEF);
        do_swap();
        do_read("rd_oor", 10'd700, BG_COLOR);
        do_read("rd_noalias", 10'd60, 16'h0000);

        // 4: read captured at the swap edge completes on its bank, and clears it
        do_write(10'd3, 16'h00AA);
        do_swap();
        @(negedge clk);
        lb.rd_en  = 1'b1;
        lb.rd_col = 10'd3;
        swap      = 1'b1;
        @(negedge clk);
        lb.rd_en  = 1'b0;
        swap      = 1'b0;
        exp_bank  = ~exp_bank;
        chk("swap_rd_bank", {31'd0, bank_sel}, {31'd0, exp_bank});
        @(negedge clk);
        chk("swap_rd", {15'd0, lb.rd_valid, lb.rd_data}, {15'd0, 1'b1, 16'h00AA});
        do_swap();
        do_read("swap_rd_clr", 10'd3, 16'h0000);

        // 5: draw in the swap cycle lands in the bank that becomes the display bank
        @(negedge clk);
        lb.wr_en   = 1'b1;
        lb.wr_col  = 10'd9;
        lb.wr_data = 16'h7C00;
        swap       = 1'b1;
        @(negedge clk);
        lb.wr_en   = 1'b0;
        swap       = 1'b0;
        exp_bank   = ~exp_bank;
        @(negedge clk);
        do_read("wr_at_swap", 10'd9, 16'h7C00);

        // 6: reset mid-scanout, then full re-init
        do_write(10'd100, 16'h5555);
        do_swap();
        do_write(10'd100, 16'h6666);
        do_swap();
        chk("pre_rst_bank", {31'd0, bank_sel}, 32'd1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i >= 2) chk("pre_rst_stream", {15'd0, lb.rd_valid, lb.rd_data}, {15'd0, 1'b1, BG_COLOR});
            lb.rd_en  = 1'b1;
            lb.rd_col = 10'(i);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, lb.rd_valid}, 32'd0);
        chk("mid_rst_bank", {31'd0, bank_sel}, 32'd0);
        chk("mid_rst_busy", {31'd0, init_busy}, 32'd1);
        lb.rd_en = 1'b0;
        reset    = 1'b0;
        exp_bank = 1'b0;
        wait_init("reinit_len");
        stream_zero("reinit_bank1");
        do_swap();
        stream_zero("reinit_bank0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
